// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake, flush and
// optional load-use bubble insertion (enabled by defining LOAD_USE_STALL_EN).

package id_ex_stage_pkg;
  localparam int unsigned ALU_FN_WIDTH = 3;

  typedef struct packed {
    logic                    mem_en;
    logic                    rw;
    logic                    data_read;
    logic                    data_write;
    logic [ALU_FN_WIDTH-1:0] alu_function;
  } ctrl_t;
endpackage

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mem_en,
  input  logic                      in_rw,
  input  logic                      in_data_read,
  input  logic                      in_data_write,
  input  logic [ALU_FN_WIDTH-1:0]   in_alu_function,
  input  logic [DATA_WIDTH-1:0]     in_src_data1,
  input  logic [DATA_WIDTH-1:0]     in_src_data2,
  input  logic [REG_ADDR_WIDTH-1:0] in_src_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] in_src_addr2,
  input  logic [REG_ADDR_WIDTH-1:0] in_dst_addr,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      ex_mem_en,
  output logic                      ex_rw,
  output logic                      ex_data_read,
  output logic                      ex_data_write,
  output logic [ALU_FN_WIDTH-1:0]   ex_alu_function,
  output logic [DATA_WIDTH-1:0]     ex_src_data1,
  output logic [DATA_WIDTH-1:0]     ex_src_data2,
  output logic [REG_ADDR_WIDTH-1:0] ex_dst_addr,
  output logic                      hazard_stall,
  output logic [15:0]               bubble_count
);

  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  ctrl_t                     ctrl_q;
  ctrl_t                     ctrl_in;
  logic [DATA_WIDTH-1:0]     data1_q;
  logic [DATA_WIDTH-1:0]     data2_q;
  logic [REG_ADDR_WIDTH-1:0] dst_q;
  logic                      load_en;
  logic                      xfer_in;
  logic                      xfer_out;
  logic                      hazard_c;

  assign ctrl_in = '{
    mem_en:       in_mem_en,
    rw:           in_rw,
    data_read:    in_data_read,
    data_write:   in_data_write,
    alu_function: in_alu_function
  };

  assign out_valid = (state_q == FULL);

`ifdef LOAD_USE_STALL_EN
  logic                 bubble_inc;
  logic [CNT_WIDTH-1:0] bubble_q;

  // Held load whose destination feeds a source of the incoming reader.
  always_comb begin
    hazard_c = out_valid && ctrl_q.mem_en && ctrl_q.rw && ctrl_q.data_write &&
               in_valid && in_data_read &&
               ((in_src_addr1 == dst_q) || (in_src_addr2 == dst_q));
  end

  // A bubble is counted when the load leaves while its consumer is held off.
  assign bubble_inc = hazard_c && xfer_out && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
    end else if (bubble_inc && (bubble_q != {CNT_WIDTH{1'b1}})) begin
      bubble_q <= bubble_q + CNT_WIDTH'(1);
    end
  end

  assign bubble_count = bubble_q;
`else
  logic unused_src_addr;

  assign hazard_c        = 1'b0;
  assign bubble_count    = '0;
  assign unused_src_addr = ^{in_src_addr1, in_src_addr2};
`endif

  assign hazard_stall = hazard_c;

  // Handshake and next-state; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    in_ready = rst_n && !flush && !hazard_c && (!out_valid || out_ready);
    xfer_in  = in_valid && in_ready;
    xfer_out = out_valid && out_ready;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d = FULL;
            load_en = 1'b1;
          end
        end
        FULL: begin
          if (xfer_out) begin
            if (xfer_in) begin
              load_en = 1'b1;
            end else begin
              state_d = EMPTY;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers keep their contents when the entry drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      data1_q <= '0;
      data2_q <= '0;
      dst_q   <= '0;
    end else if (load_en) begin
      ctrl_q  <= ctrl_in;
      data1_q <= in_src_data1;
      data2_q <= in_src_data2;
      dst_q   <= in_dst_addr;
    end
  end

  assign ex_mem_en       = ctrl_q.mem_en;
  assign ex_rw           = ctrl_q.rw;
  assign ex_data_read    = ctrl_q.data_read;
  assign ex_data_write   = ctrl_q.data_write;
  assign ex_alu_function = ctrl_q.alu_function;
  assign ex_src_data1    = data1_q;
  assign ex_src_data2    = data2_q;
  assign ex_dst_addr     = dst_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; expectations follow LOAD_USE_STALL_EN.

module tb_id_ex_stage;

  typedef struct packed {
    logic        mem_en;
    logic        rw;
    logic        dr;
    logic        dw;
    logic [2:0]  fn;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  a1;
    logic [2:0]  a2;
    logic [2:0]  dst;
  } instr_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mem_en;
  logic        in_rw;
  logic        in_data_read;
  logic        in_data_write;
  logic [2:0]  in_alu_function;
  logic [15:0] in_src_data1;
  logic [15:0] in_src_data2;
  logic [2:0]  in_src_addr1;
  logic [2:0]  in_src_addr2;
  logic [2:0]  in_dst_addr;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic        ex_mem_en;
  logic        ex_rw;
  logic        ex_data_read;
  logic        ex_data_write;
  logic [2:0]  ex_alu_function;
  logic [15:0] ex_src_data1;
  logic [15:0] ex_src_data2;
  logic [2:0]  ex_dst_addr;
  logic        hazard_stall;
  logic [15:0] bubble_count;

  int     n_checks;
  int     n_fail;
  instr_t q[$];
  logic   stall_en;
  logic [15:0] exp_bubbles;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_en(in_mem_en), .in_rw(in_rw), .in_data_read(in_data_read),
    .in_data_write(in_data_write), .in_alu_function(in_alu_function),
    .in_src_data1(in_src_data1), .in_src_data2(in_src_data2),
    .in_src_addr1(in_src_addr1), .in_src_addr2(in_src_addr2),
    .in_dst_addr(in_dst_addr), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .ex_mem_en(ex_mem_en), .ex_rw(ex_rw),
    .ex_data_read(ex_data_read), .ex_data_write(ex_data_write),
    .ex_alu_function(ex_alu_function), .ex_src_data1(ex_src_data1),
    .ex_src_data2(ex_src_data2), .ex_dst_addr(ex_dst_addr),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_of(input instr_t i);
    return 64'({i.mem_en, i.rw, i.dr, i.dw, i.fn, i.d1, i.d2, i.dst});
  endfunction

  function automatic logic [63:0] dut_entry();
    return 64'({ex_mem_en, ex_rw, ex_data_read, ex_data_write, ex_alu_function,
                ex_src_data1, ex_src_data2, ex_dst_addr});
  endfunction

  function automatic instr_t mk(input logic mem_en, input logic rw, input logic dr,
                                input logic dw, input logic [2:0] fn,
                                input logic [15:0] d1, input logic [15:0] d2,
                                input logic [2:0] a1, input logic [2:0] a2,
                                input logic [2:0] dst);
    instr_t i;
    i = '{mem_en: mem_en, rw: rw, dr: dr, dw: dw, fn: fn, d1: d1, d2: d2,
          a1: a1, a2: a2, dst: dst};
    return i;
  endfunction

  // One clock cycle: drive, check against scoreboard head, update scoreboard.
  task automatic cycle(input instr_t ins, input logic iv, input logic ordy,
                       input logic fl, input logic exp_rdy, input logic exp_haz);
    in_valid        = iv;
    in_mem_en       = ins.mem_en;
    in_rw           = ins.rw;
    in_data_read    = ins.dr;
    in_data_write   = ins.dw;
    in_alu_function = ins.fn;
    in_src_data1    = ins.d1;
    in_src_data2    = ins.d2;
    in_src_addr1    = ins.a1;
    in_src_addr2    = ins.a2;
    in_dst_addr     = ins.dst;
    out_ready       = ordy;
    flush           = fl;
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("hazard_stall", 64'(hazard_stall), 64'(exp_haz));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("ex_entry", dut_entry(), exp_of(q[0]));
    if (fl) begin
      q.delete();
    end else begin
      if ((q.size() != 0) && ordy) void'(q.pop_front());
      if (iv && exp_rdy) q.push_back(ins);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    instr_t nop, add, ld, dep;
    instr_t s[4];
    n_checks    = 0;
    n_fail      = 0;
`ifdef LOAD_USE_STALL_EN
    stall_en = 1'b1;
`else
    stall_en = 1'b0;
`endif
    nop = mk(0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
    rst_n = 1'b0;
    in_valid = 1'b0; in_mem_en = 1'b0; in_rw = 1'b0; in_data_read = 1'b0;
    in_data_write = 1'b0; in_alu_function = '0; in_src_data1 = '0;
    in_src_data2 = '0; in_src_addr1 = '0; in_src_addr2 = '0; in_dst_addr = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_hazard", 64'(hazard_stall), 64'd0);
    chk("rst_bubbles", 64'(bubble_count), 64'd0);
    chk("rst_entry", dut_entry(), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD, then drain
    add = mk(0, 0, 1, 1, 3'b011, 16'h0003, 16'h0004, 3'd1, 3'd3, 3'd4);
    cycle(add, 1, 0, 0, 1, 0);
    chk("add_data1", 64'(ex_src_data1), 64'h3);
    chk("add_dr_dw", 64'({ex_data_read, ex_data_write}), 64'h3);
    cycle(nop, 0, 1, 0, 1, 0);

    // Back-to-back stream of four
    for (int k = 0; k < 4; k++)
      s[k] = mk(0, k[0], 1, 0, 3'(k + 1), 16'(16'h1000 + k), 16'(16'h2000 + k),
                3'(k), 3'(k + 1), 3'(k + 2));
    for (int k = 0; k < 4; k++) cycle(s[k], 1, 1, 0, 1, 0);
    cycle(nop, 0, 1, 0, 1, 0);
    cycle(nop, 0, 1, 0, 1, 0);

    // Backpressure for three cycles, then simultaneous out and in
    s[0] = mk(0, 1, 0, 1, 3'd5, 16'hAAAA, 16'h5555, 3'd6, 3'd7, 3'd1);
    s[1] = mk(1, 0, 1, 0, 3'd6, 16'h1234, 16'h4321, 3'd2, 3'd4, 3'd6);
    cycle(s[0], 1, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) cycle(s[1], 1, 0, 0, 0, 0);
    cycle(s[1], 1, 1, 0, 1, 0);
    cycle(nop, 0, 1, 0, 1, 0);

    // Load-use: load to r2, dependent add reading r2
    ld  = mk(1, 1, 0, 1, 3'd0, 16'h00F0, 16'h000F, 3'd0, 3'd1, 3'd2);
    dep = mk(0, 0, 1, 1, 3'b011, 16'h0007, 16'h0008, 3'd2, 3'd5, 3'd3);
    cycle(ld, 1, 1, 0, 1, 0);
    if (stall_en) begin
      cycle(dep, 1, 1, 0, 0, 1);
      cycle(dep, 1, 1, 0, 1, 0);
      exp_bubbles = 16'd1;
    end else begin
      cycle(dep, 1, 1, 0, 1, 0);
      exp_bubbles = 16'd0;
    end
    chk("bubbles_after_hazard", 64'(bubble_count), 64'(exp_bubbles));
    cycle(nop, 0, 1, 0, 1, 0);

    // Flush a held load while its consumer waits; flush must not count a bubble
    ld  = mk(1, 1, 0, 1, 3'd2, 16'hBEEF, 16'hCAFE, 3'd0, 3'd0, 3'd5);
    dep = mk(0, 0, 1, 0, 3'd4, 16'h0101, 16'h0202, 3'd1, 3'd5, 3'd6);
    cycle(ld, 1, 0, 0, 1, 0);
    cycle(dep, 1, 1, 1, 0, stall_en);
    cycle(nop, 0, 1, 0, 1, 0);
    chk("bubbles_after_flush", 64'(bubble_count), 64'(exp_bubbles));

    // Asynchronous reset while FULL
    s[2] = mk(0, 1, 1, 1, 3'd7, 16'h7777, 16'h8888, 3'd3, 3'd4, 3'd7);
    cycle(s[2], 1, 0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_entry", dut_entry(), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    chk("async_bubbles", 64'(bubble_count), 64'd0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    s[3] = mk(0, 0, 0, 1, 3'd1, 16'h0F0F, 16'hF0F0, 3'd5, 3'd6, 3'd2);
    cycle(s[3], 1, 1, 0, 1, 0);
    cycle(nop, 0, 1, 0, 1, 0);
    cycle(nop, 0, 1, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
